// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch (IF) and
// load/store (D): one grant at a time, round-robin on ties, one memory cycle per grant.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be in 1..4");
    end

    // Handshake: a requester raises req with stable address/data and holds it until
    // its ready pulse; ready is high for exactly one cycle (the DONE state). A req
    // still high in the IDLE cycle after DONE counts as a fresh request.
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic                  last_d_q, last_d_d;   // 1: D was granted most recently
    logic                  win_d_q, win_d_d;     // 1: current transaction belongs to D
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  grant_d;

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        win_d_d    = win_d_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        grant_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    // D wins when alone, or on a tie when IF was served last.
                    grant_d  = d_req && (!if_req || !last_d_q);
                    win_d_d  = grant_d;
                    last_d_d = grant_d;
                    we_d     = grant_d && d_we;
                    addr_d   = grant_d ? d_addr : if_addr;
                    wdata_d  = grant_d ? d_wdata : wdata_q;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 3'(MEM_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (!win_d_q) begin
                        if_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b1;
            win_d_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= 3'd0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            win_d_q    <= win_d_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Outputs are forced low while reset_n is low so an aborted access drops its
    // strobe in the very first reset cycle. addr_q/wdata_q only change on a grant,
    // so mem_addr/mem_wdata hold their last driven values outside ISSUE.
    assign mem_en    = reset_n && (state_q == ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = reset_n ? addr_q : '0;
    assign mem_wdata = reset_n ? wdata_q : '0;
    assign if_ready  = reset_n && (state_q == DONE) && !win_d_q;
    assign d_ready   = reset_n && (state_q == DONE) && win_d_q;
    assign if_rdata  = reset_n ? if_rdata_q : '0;
    assign d_rdata   = reset_n ? d_rdata_q : '0;
    assign busy      = reset_n && (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1, one at
// MEM_LATENCY=4, each backed by a small memory model with exact read latency.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A: MEM_LATENCY = 1 ----------------
    logic        a_rst_n, a_if_req, a_d_req, a_d_we;
    logic [31:0] a_if_addr, a_d_addr, a_d_wdata;
    logic        a_if_ready, a_d_ready, a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_a (
        .clk(clk), .reset_n(a_rst_n),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ready(a_if_ready), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_ready(a_d_ready), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    // ---------------- instance B: MEM_LATENCY = 4 ----------------
    logic        b_rst_n, b_if_req, b_d_req, b_d_we;
    logic [31:0] b_if_addr, b_d_addr, b_d_wdata;
    logic        b_if_ready, b_d_ready, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(4)) u_b (
        .clk(clk), .reset_n(b_rst_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ready(b_d_ready), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // ---------------- memory models ----------------
    // Word index {addr[22], addr[3:2]}: 0x00400000->4, 0x10010000->0, 0x10010004->1.
    function automatic logic [2:0] idx(input logic [31:0] a);
        return {a[22], a[3:2]};
    endfunction

    logic [31:0] a_mem [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h20080005, 32'h0, 32'h0, 32'h0};
    logic [31:0] b_mem [8] = '{32'h0, 32'h0000002A, 32'h0, 32'h0, 32'h12345678, 32'h0, 32'h0, 32'h0};
    logic [2:0]  a_pend = 3'd0, b_pend = 3'd0;
    logic [31:0] a_pdata = 32'h0, b_pdata = 32'h0;

    // Read data is valid only in the cycle exactly MEM_LATENCY after mem_en.
    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) a_mem[idx(a_mem_addr)] <= a_mem_wdata;
        if (a_mem_en && !a_mem_we) begin
            a_pend  <= 3'd1;
            a_pdata <= a_mem[idx(a_mem_addr)];
        end else if (a_pend != 3'd0) begin
            a_pend <= a_pend - 3'd1;
        end
        if (b_mem_en && b_mem_we) b_mem[idx(b_mem_addr)] <= b_mem_wdata;
        if (b_mem_en && !b_mem_we) begin
            b_pend  <= 3'd4;
            b_pdata <= b_mem[idx(b_mem_addr)];
        end else if (b_pend != 3'd0) begin
            b_pend <= b_pend - 3'd1;
        end
    end
    assign a_mem_rdata = (a_pend == 3'd1) ? a_pdata : 32'h5A5A5A5A;
    assign b_mem_rdata = (b_pend == 3'd1) ? b_pdata : 32'h5A5A5A5A;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One isolated transaction on A; cycle 0 is the cycle req is first sampled.
    task automatic a_single(input logic is_d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rd,
                            input logic [31:0] exp_other);
        for (int c = 0; c <= 4; c++) begin
            if (c == 0) begin
                if (is_d) begin
                    a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
                end else begin
                    a_if_req = 1'b1; a_if_addr = addr;
                end
            end
            if (c == 4) begin
                a_if_req = 1'b0; a_d_req = 1'b0;
            end
            #1;
            chk1("a_mem_en", a_mem_en, c == 1);
            chk1("a_busy", a_busy, c >= 1 && c <= 3);
            chk1("a_if_ready", a_if_ready, !is_d && c == 3);
            chk1("a_d_ready", a_d_ready, is_d && c == 3);
            if (c == 1) begin
                chk("a_mem_addr", a_mem_addr, addr);
                chk1("a_mem_we", a_mem_we, we);
                if (we) chk("a_mem_wdata", a_mem_wdata, wdata);
            end
            if (c == 3) begin
                chk1("a_mem_we_off", a_mem_we, 1'b0);
                chk("a_mem_addr_hold", a_mem_addr, addr);
                chk("a_rdata_win", is_d ? a_d_rdata : a_if_rdata, exp_rd);
                chk("a_rdata_lose", is_d ? a_if_rdata : a_d_rdata, exp_other);
            end
            tick();
        end
    endtask

    task automatic b_single(input logic is_d, input logic [31:0] addr,
                            input logic [31:0] exp_rd, input logic [31:0] exp_other);
        for (int c = 0; c <= 7; c++) begin
            if (c == 0) begin
                if (is_d) begin
                    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = addr;
                end else begin
                    b_if_req = 1'b1; b_if_addr = addr;
                end
            end
            if (c == 7) begin
                b_if_req = 1'b0; b_d_req = 1'b0;
            end
            #1;
            chk1("b_mem_en", b_mem_en, c == 1);
            chk1("b_busy", b_busy, c >= 1 && c <= 6);
            chk1("b_if_ready", b_if_ready, !is_d && c == 6);
            chk1("b_d_ready", b_d_ready, is_d && c == 6);
            if (c == 1) chk("b_mem_addr", b_mem_addr, addr);
            if (c == 6) begin
                chk("b_rdata_win", is_d ? b_d_rdata : b_if_rdata, exp_rd);
                chk("b_rdata_lose", is_d ? b_if_rdata : b_d_rdata, exp_other);
            end
            tick();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        a_rst_n = 1'b0; a_if_req = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0;
        a_if_addr = '0; a_d_addr = '0; a_d_wdata = '0;
        b_rst_n = 1'b0; b_if_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_if_addr = '0; b_d_addr = '0; b_d_wdata = '0;
        tick();
        tick();

        // Reset state
        chk1("rst_a_busy", a_busy, 1'b0);
        chk1("rst_a_mem_en", a_mem_en, 1'b0);
        chk1("rst_a_ready", a_if_ready | a_d_ready, 1'b0);
        chk("rst_a_mem_addr", a_mem_addr, 32'h0);
        chk("rst_a_if_rdata", a_if_rdata, 32'h0);
        chk("rst_b_busy", b_busy, 1'b0);
        chk("rst_b_d_rdata", b_d_rdata, 32'h0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick();

        // Single IF fetch, latency 1
        a_single(1'b0, 1'b0, 32'h00400000, 32'h0, 32'h20080005, 32'h0);
        // Store then load of the same address; store leaves d_rdata untouched
        a_single(1'b1, 1'b1, 32'h10010000, 32'hDEADBEEF, 32'h0, 32'h20080005);
        a_single(1'b1, 1'b0, 32'h10010000, 32'h0, 32'hDEADBEEF, 32'h20080005);

        // Fresh reset, then both ports held for four transactions
        a_rst_n = 1'b0;
        tick();
        chk("rst2_a_d_rdata", a_d_rdata, 32'h0);
        a_rst_n = 1'b1;
        tick();
        for (int c = 0; c <= 16; c++) begin
            if (c == 0) begin
                a_if_req = 1'b1; a_if_addr = 32'h00400000;
                a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h10010000;
            end
            if (c == 16) begin
                a_if_req = 1'b0; a_d_req = 1'b0;
            end
            #1;
            chk1("rr_mem_en", a_mem_en, (c % 4 == 1) && c < 16);
            chk1("rr_busy", a_busy, (c % 4 != 0) && c < 16);
            chk1("rr_if_ready", a_if_ready, c == 3 || c == 11);
            chk1("rr_d_ready", a_d_ready, c == 7 || c == 15);
            if ((c % 4 == 1) && c < 16)
                chk("rr_mem_addr", a_mem_addr, (c % 8 == 1) ? 32'h00400000 : 32'h10010000);
            if (c == 3 || c == 11) chk("rr_if_rdata", a_if_rdata, 32'h20080005);
            if (c == 7 || c == 15) begin
                chk("rr_d_rdata", a_d_rdata, 32'hDEADBEEF);
                chk("rr_if_hold", a_if_rdata, 32'h20080005);
            end
            tick();
        end

        // D load, latency 4
        b_single(1'b1, 32'h10010004, 32'h0000002A, 32'h0);

        // IF fetch aborted by reset while in WAIT
        for (int c = 0; c <= 9; c++) begin
            if (c == 0) begin
                b_if_req = 1'b1; b_if_addr = 32'h00400000;
            end
            if (c == 3) begin
                b_rst_n = 1'b0; b_if_req = 1'b0;
            end
            if (c == 5) b_rst_n = 1'b1;
            #1;
            chk1("abort_if_ready", b_if_ready, 1'b0);
            chk1("abort_mem_en", b_mem_en, c == 1);
            chk1("abort_busy", b_busy, c == 1 || c == 2);
            if (c == 3) begin
                chk("abort_mem_addr", b_mem_addr, 32'h0);
                chk("abort_d_rdata", b_d_rdata, 32'h0);
            end
            tick();
        end
        b_single(1'b0, 32'h00400000, 32'h12345678, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
